fwd_hazard_unit: RTL and testbench

//  Parametrised N-lane forwarding + load-use hazard unit for the superscalar pipeline; successor to the dual-lane forwarder.
//  Per ID/EX source operand, selects the youngest in-flight producer (EX/MEM or MEM/WB, any lane) or the register file.

---
 rtl/fwd_hazard_unit_pkg.sv | 25 ++
 rtl/fwd_hazard_unit_if.sv | 40 ++++
 rtl/fwd_hazard_unit_src_sel.sv | 59 +++++
 rtl/fwd_hazard_unit.sv | 143 ++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared stage codes, stall FSM state type and width helpers for the forwarding/hazard unit.
package fwd_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } stall_state_t;

    function automatic int lane_w(input int n_lanes);
        return (n_lanes > 1) ? $clog2(n_lanes) : 1;
    endfunction

    function automatic int sel_w(input int n_lanes);
        return 2 + lane_w(n_lanes);
    endfunction

    function automatic int cnt_w(input int load_lat);
        return (load_lat > 1) ? $clog2(load_lat) : 1;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle of the forwarding/hazard unit: ID/EX sources, EX/MEM and MEM/WB producers, results.
interface fwd_hazard_unit_if #(
    parameter int N_LANES = 2,
    parameter int N_SRC   = 3,
    parameter int REG_AW  = 3
);
    import fwd_pkg::*;

    localparam int SEL_W = sel_w(N_LANES);

    logic [N_LANES*N_SRC*REG_AW-1:0] id_ex_src;
    logic [N_LANES*N_SRC-1:0]        id_ex_src_vld;
    logic [N_LANES*REG_AW-1:0]       ex_mem_rd;
    logic [N_LANES-1:0]              ex_mem_we;
    logic [N_LANES-1:0]              ex_mem_ld;
    logic [N_LANES-1:0]              ex_mem_fwe;
    logic [N_LANES-1:0]              ex_mem_n;
    logic [N_LANES*REG_AW-1:0]       mem_wb_rd;
    logic [N_LANES-1:0]              mem_wb_we;
    logic [N_LANES-1:0]              mem_wb_fwe;
    logic [N_LANES-1:0]              mem_wb_n;
    logic [N_LANES*N_SRC*SEL_W-1:0]  fwd_sel;
    logic                            stall;
    logic                            n_fwd;

    modport master (
        output id_ex_src, id_ex_src_vld,
        output ex_mem_rd, ex_mem_we, ex_mem_ld, ex_mem_fwe, ex_mem_n,
        output mem_wb_rd, mem_wb_we, mem_wb_fwe, mem_wb_n,
        input  fwd_sel, stall, n_fwd
    );

    modport slave (
        input  id_ex_src, id_ex_src_vld,
        input  ex_mem_rd, ex_mem_we, ex_mem_ld, ex_mem_fwe, ex_mem_n,
        input  mem_wb_rd, mem_wb_we, mem_wb_fwe, mem_wb_n,
        output fwd_sel, stall, n_fwd
    );

endinterface

// File: rtl/fwd_hazard_unit_src_sel.sv
// Priority match for one source operand: youngest EX/MEM producer, then youngest MEM/WB, else regfile.
module fwd_src_sel
    import fwd_pkg::*;
#(
    parameter int N_LANES = 2,
    parameter int REG_AW  = 3
) (
    input  logic [REG_AW-1:0]          src,
    input  logic                       vld,
    input  logic [N_LANES*REG_AW-1:0]  ex_mem_rd,
    input  logic [N_LANES-1:0]         ex_mem_we,
    input  logic [N_LANES-1:0]         ex_mem_ld,
    input  logic [N_LANES*REG_AW-1:0]  mem_wb_rd,
    input  logic [N_LANES-1:0]         mem_wb_we,
    output logic [sel_w(N_LANES)-1:0]  sel,
    output logic                       hazard
);

    localparam int LW = lane_w(N_LANES);

    logic          live;
    logic          ex_hit;
    logic          ex_ld;
    logic          wb_hit;
    logic [LW-1:0] ex_lane;
    logic [LW-1:0] wb_lane;

    // Ascending scan: the last hit is the highest, i.e. youngest, lane.
    always_comb begin
        live    = vld && (src != '0);
        ex_hit  = 1'b0;
        ex_ld   = 1'b0;
        ex_lane = '0;
        wb_hit  = 1'b0;
        wb_lane = '0;
        for (int l = 0; l < N_LANES; l++) begin
            if (live && ex_mem_we[l] && (ex_mem_rd[l*REG_AW +: REG_AW] == src)) begin
                ex_hit  = 1'b1;
                ex_ld   = ex_mem_ld[l];
                ex_lane = LW'(l);
            end
            if (live && mem_wb_we[l] && (mem_wb_rd[l*REG_AW +: REG_AW] == src)) begin
                wb_hit  = 1'b1;
                wb_lane = LW'(l);
            end
        end

        // A youngest-match load has no data yet; report the older fallback path.
        if (ex_hit && !ex_ld) begin
            sel = {ex_lane, FWD_EXMEM};
        end else if (wb_hit) begin
            sel = {wb_lane, FWD_MEMWB};
        end else begin
            sel = {LW'(0), FWD_RF};
        end
        hazard = ex_hit && ex_ld;
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// N-lane operand forwarding, load-use stall FSM and N-flag forwarding.
// Optional FWD_PERF_CNT_EN adds saturating stall_cnt / hazard_cnt outputs.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int N_LANES  = 2,
    parameter int N_SRC    = 3,
    parameter int REG_AW   = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_hazard_unit_if.slave  bus
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       hazard_cnt
`endif
);

    localparam int SW    = sel_w(N_LANES);
    localparam int CW    = cnt_w(LOAD_LAT);
    localparam int N_OPS = N_LANES * N_SRC;

    logic [N_OPS-1:0] hazard_vec;
    logic             hazard;
    stall_state_t     state;
    stall_state_t     state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             flag_q;
    logic             ex_flag_any;
    logic             ex_flag;
    logic             wb_flag_any;
    logic             wb_flag;
    logic             stall_int;
    logic             n_fwd_int;

    for (genvar i = 0; i < N_OPS; i++) begin : g_src
        fwd_src_sel #(
            .N_LANES (N_LANES),
            .REG_AW  (REG_AW)
        ) u_sel (
            .src       (bus.id_ex_src[i*REG_AW +: REG_AW]),
            .vld       (bus.id_ex_src_vld[i]),
            .ex_mem_rd (bus.ex_mem_rd),
            .ex_mem_we (bus.ex_mem_we),
            .ex_mem_ld (bus.ex_mem_ld),
            .mem_wb_rd (bus.mem_wb_rd),
            .mem_wb_we (bus.mem_wb_we),
            .sel       (bus.fwd_sel[i*SW +: SW]),
            .hazard    (hazard_vec[i])
        );
    end

    assign hazard = |hazard_vec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The detection cycle already stalls combinationally, so STALL covers the
    // remaining LOAD_LAT-1 cycles; cnt holds the stall cycles still owed.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (hazard && (LOAD_LAT > 1)) begin
                    state_nxt = STALL;
                    cnt_nxt   = CW'(LOAD_LAT - 1);
                end
            end
            STALL: begin
                if (cnt <= CW'(1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        ex_flag_any = |bus.ex_mem_fwe;
        wb_flag_any = |bus.mem_wb_fwe;
        ex_flag     = 1'b0;
        wb_flag     = 1'b0;
        for (int l = 0; l < N_LANES; l++) begin
            if (bus.ex_mem_fwe[l]) ex_flag = bus.ex_mem_n[l];
            if (bus.mem_wb_fwe[l]) wb_flag = bus.mem_wb_n[l];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_q <= 1'b0;
        end else if (wb_flag_any) begin
            flag_q <= wb_flag;
        end
    end

    always_comb begin
        stall_int = (state == STALL) || hazard;
        n_fwd_int = flag_q;
        if (ex_flag_any) begin
            n_fwd_int = ex_flag;
        end else if (wb_flag_any) begin
            n_fwd_int = wb_flag;
        end
    end

    assign bus.stall = stall_int;
    assign bus.n_fwd = n_fwd_int;

`ifdef FWD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            hazard_cnt <= '0;
        end else begin
            if (stall_int && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if ((state == RUN) && hazard && (hazard_cnt != '1)) begin
                hazard_cnt <= hazard_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: three units (LOAD_LAT 1/2/3) share directed stimulus; a negedge monitor checks them.
module tb_fwd_hazard_unit;

    typedef struct packed {
        logic [17:0] src;
        logic [5:0]  vld;
        logic [5:0]  ex_rd;
        logic [1:0]  ex_we;
        logic [1:0]  ex_ld;
        logic [1:0]  ex_fwe;
        logic [1:0]  ex_n;
        logic [5:0]  wb_rd;
        logic [1:0]  wb_we;
        logic [1:0]  wb_fwe;
        logic [1:0]  wb_n;
    } stim_t;

    typedef struct packed {
        logic [1:0]  dut;
        logic [17:0] sel;
        logic        stall;
        logic        n;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    stim_t s = '0;
    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.N_LANES(2), .N_SRC(3), .REG_AW(3)) bus1 ();
    fwd_hazard_unit_if #(.N_LANES(2), .N_SRC(3), .REG_AW(3)) bus2 ();
    fwd_hazard_unit_if #(.N_LANES(2), .N_SRC(3), .REG_AW(3)) bus3 ();

    assign {bus1.id_ex_src, bus1.id_ex_src_vld, bus1.ex_mem_rd, bus1.ex_mem_we, bus1.ex_mem_ld,
            bus1.ex_mem_fwe, bus1.ex_mem_n, bus1.mem_wb_rd, bus1.mem_wb_we, bus1.mem_wb_fwe,
            bus1.mem_wb_n} = s;
    assign {bus2.id_ex_src, bus2.id_ex_src_vld, bus2.ex_mem_rd, bus2.ex_mem_we, bus2.ex_mem_ld,
            bus2.ex_mem_fwe, bus2.ex_mem_n, bus2.mem_wb_rd, bus2.mem_wb_we, bus2.mem_wb_fwe,
            bus2.mem_wb_n} = s;
    assign {bus3.id_ex_src, bus3.id_ex_src_vld, bus3.ex_mem_rd, bus3.ex_mem_we, bus3.ex_mem_ld,
            bus3.ex_mem_fwe, bus3.ex_mem_n, bus3.mem_wb_rd, bus3.mem_wb_we, bus3.mem_wb_fwe,
            bus3.mem_wb_n} = s;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_cnt1, hazard_cnt1, stall_cnt2, hazard_cnt2, stall_cnt3, hazard_cnt3;
`endif

    fwd_hazard_unit #(.N_LANES(2), .N_SRC(3), .REG_AW(3), .LOAD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
`ifdef FWD_PERF_CNT_EN
        , .stall_cnt(stall_cnt1), .hazard_cnt(hazard_cnt1)
`endif
    );
    fwd_hazard_unit #(.N_LANES(2), .N_SRC(3), .REG_AW(3), .LOAD_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
`ifdef FWD_PERF_CNT_EN
        , .stall_cnt(stall_cnt2), .hazard_cnt(hazard_cnt2)
`endif
    );
    fwd_hazard_unit #(.N_LANES(2), .N_SRC(3), .REG_AW(3), .LOAD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
`ifdef FWD_PERF_CNT_EN
        , .stall_cnt(stall_cnt3), .hazard_cnt(hazard_cnt3)
`endif
    );

    function automatic logic [17:0] esel(input int lane, input int op, input logic [2:0] code);
        logic [17:0] v;
        v = '0;
        v[(lane*3+op)*3 +: 3] = code;
        return v;
    endfunction

    task automatic set_src(input int lane, input int op, input int addr);
        s.src[(lane*3+op)*3 +: 3] = 3'(addr);
        s.vld[lane*3+op] = 1'b1;
    endtask

    task automatic ex_w(input int lane, input int rd, input logic ld);
        s.ex_rd[lane*3 +: 3] = 3'(rd);
        s.ex_we[lane] = 1'b1;
        s.ex_ld[lane] = ld;
    endtask

    task automatic wb_w(input int lane, input int rd);
        s.wb_rd[lane*3 +: 3] = 3'(rd);
        s.wb_we[lane] = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        s = '0;
    endtask

    task automatic exp_all(input string nm, input logic [17:0] sel,
                           input logic st1, input logic st2, input logic st3, input logic n);
        exp_q.push_back('{dut: 2'd0, sel: sel, stall: st1, n: n}); name_q.push_back(nm);
        exp_q.push_back('{dut: 2'd1, sel: sel, stall: st2, n: n}); name_q.push_back(nm);
        exp_q.push_back('{dut: 2'd2, sel: sel, stall: st3, n: n}); name_q.push_back(nm);
    endtask

    exp_t        m_e;
    string       m_nm;
    logic [17:0] m_sel;
    logic        m_st;
    logic        m_n;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            m_e  = exp_q.pop_front();
            m_nm = name_q.pop_front();
            case (m_e.dut)
                2'd0:    begin m_sel = bus1.fwd_sel; m_st = bus1.stall; m_n = bus1.n_fwd; end
                2'd1:    begin m_sel = bus2.fwd_sel; m_st = bus2.stall; m_n = bus2.n_fwd; end
                default: begin m_sel = bus3.fwd_sel; m_st = bus3.stall; m_n = bus3.n_fwd; end
            endcase
            n_cmp++;
            if ({m_sel, m_st, m_n} !== {m_e.sel, m_e.stall, m_e.n}) begin
                n_bad++;
                $display("FAIL %s lat%0d: got sel=%b stall=%b n=%b, want sel=%b stall=%b n=%b",
                         m_nm, m_e.dut + 1, m_sel, m_st, m_n, m_e.sel, m_e.stall, m_e.n);
            end
        end
    end

`ifdef FWD_PERF_CNT_EN
    task automatic chk_cnt(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        repeat (2) next_cycle();
        exp_all("reset", '0, 0, 0, 0, 0);
        rst_n = 1'b1;

        next_cycle(); set_src(1, 0, 3); ex_w(0, 3, 0);
        exp_all("exmem_l0", esel(1, 0, 3'b010), 0, 0, 0, 0);
        next_cycle(); set_src(1, 0, 3); ex_w(0, 3, 0); ex_w(1, 3, 0);
        exp_all("exmem_l1_younger", esel(1, 0, 3'b110), 0, 0, 0, 0);
        next_cycle(); set_src(0, 1, 5); ex_w(0, 5, 0); wb_w(1, 5);
        exp_all("exmem_beats_memwb", esel(0, 1, 3'b010), 0, 0, 0, 0);
        next_cycle(); set_src(0, 1, 5); wb_w(0, 5); wb_w(1, 5);
        exp_all("memwb_l1_younger", esel(0, 1, 3'b101), 0, 0, 0, 0);
        next_cycle(); set_src(1, 2, 0); ex_w(0, 0, 0); wb_w(1, 0);
        exp_all("addr0_never_fwd", '0, 0, 0, 0, 0);
        next_cycle(); set_src(0, 2, 4); s.vld[2] = 1'b0; ex_w(1, 4, 0);
        exp_all("vld0_no_fwd", '0, 0, 0, 0, 0);
        next_cycle(); set_src(1, 1, 6); s.ex_rd[2:0] = 3'd6; s.wb_rd[2:0] = 3'd6;
        exp_all("we0_no_fwd", '0, 0, 0, 0, 0);
        next_cycle(); set_src(0, 0, 1); set_src(1, 2, 7); ex_w(1, 1, 0); wb_w(0, 7);
        exp_all("two_srcs", esel(0, 0, 3'b110) | esel(1, 2, 3'b001), 0, 0, 0, 0);
        next_cycle(); set_src(0, 0, 2); ex_w(0, 2, 1); ex_w(1, 2, 0);
        exp_all("young_alu_over_load", esel(0, 0, 3'b110), 0, 0, 0, 0);

        next_cycle(); set_src(0, 0, 2); ex_w(0, 2, 1); wb_w(0, 2);
        exp_all("ldu_fallback_memwb", esel(0, 0, 3'b001), 1, 1, 1, 0);
        next_cycle(); exp_all("ldu_c1", '0, 0, 1, 1, 0);
        next_cycle(); exp_all("ldu_c2", '0, 0, 0, 1, 0);
        next_cycle(); exp_all("ldu_c3", '0, 0, 0, 0, 0);

        next_cycle(); set_src(0, 0, 2); ex_w(0, 2, 1);
        exp_all("ldu_again", '0, 1, 1, 1, 0);
        next_cycle(); set_src(0, 0, 2); ex_w(0, 2, 1);
        exp_all("ldu_held", '0, 1, 1, 1, 0);
        next_cycle(); exp_all("ldu_ignored_c1", '0, 0, 0, 1, 0);
        next_cycle(); exp_all("ldu_ignored_c2", '0, 0, 0, 0, 0);

        next_cycle(); s.wb_fwe = 2'b01; s.wb_n = 2'b01;
        exp_all("flag_wb_l0", '0, 0, 0, 0, 1);
        next_cycle(); exp_all("flag_q_1", '0, 0, 0, 0, 1);
        next_cycle(); s.wb_fwe = 2'b11; s.wb_n = 2'b01;
        exp_all("flag_wb_l1_wins", '0, 0, 0, 0, 0);
        next_cycle(); exp_all("flag_q_0", '0, 0, 0, 0, 0);
        next_cycle(); s.ex_fwe = 2'b01; s.ex_n = 2'b01; s.wb_fwe = 2'b10; s.wb_n = 2'b10;
        exp_all("flag_ex_beats_wb", '0, 0, 0, 0, 1);
        next_cycle(); exp_all("flag_q_from_wb", '0, 0, 0, 0, 1);
        next_cycle(); s.ex_fwe = 2'b11; s.ex_n = 2'b01;
        exp_all("flag_ex_l1_wins", '0, 0, 0, 0, 0);
        next_cycle(); exp_all("flag_q_kept", '0, 0, 0, 0, 1);

        next_cycle(); set_src(1, 1, 4); ex_w(1, 4, 1);
        exp_all("rst_ldu", '0, 1, 1, 1, 1);
        next_cycle(); rst_n = 1'b0;
        exp_all("rst_in_stall", '0, 0, 1, 1, 1);
        next_cycle(); rst_n = 1'b1;
        exp_all("rst_aborts_stall", '0, 0, 0, 0, 0);

        for (int k = 0; k < 2; k++) begin
            next_cycle(); set_src(0, 2, 3); ex_w(0, 3, 1);
            exp_all("perf_ldu", '0, 1, 1, 1, 0);
            next_cycle(); exp_all("perf_c1", '0, 0, 1, 1, 0);
            next_cycle(); exp_all("perf_c2", '0, 0, 0, 1, 0);
        end
        next_cycle(); exp_all("perf_done", '0, 0, 0, 0, 0);
`ifdef FWD_PERF_CNT_EN
        chk_cnt("stall_cnt_lat1", stall_cnt1, 32'd2);
        chk_cnt("hazard_cnt_lat1", hazard_cnt1, 32'd2);
        chk_cnt("stall_cnt_lat2", stall_cnt2, 32'd4);
        chk_cnt("hazard_cnt_lat2", hazard_cnt2, 32'd2);
        chk_cnt("stall_cnt_lat3", stall_cnt3, 32'd6);
        chk_cnt("hazard_cnt_lat3", hazard_cnt3, 32'd2);
`endif

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
